// File: rtl/mlp_layer_engine_if.sv
// Bus bundle for mlp_layer_engine: memory read ports, control and streamed results.
// The engine is the master: it drives all addresses and the result outputs.
interface mlp_layer_engine_if #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 64,
    parameter int W      = 16,
    parameter int BIAS_W = 32
);
    localparam int IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int WA_W   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;

    logic                     start;
    logic                     act_mode;
    logic [IN_AW-1:0]         in_addr;
    logic signed [W-1:0]      in_data;
    logic [WA_W-1:0]          w_addr;
    logic signed [W-1:0]      w_data;
    logic [OUT_AW-1:0]        b_addr;
    logic signed [BIAS_W-1:0] b_data;
    logic                     out_valid;
    logic [OUT_AW-1:0]        out_idx;
    logic signed [W-1:0]      out_data;
    logic [OUT_AW-1:0]        argmax_idx;
    logic signed [W-1:0]      argmax_val;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, act_mode, in_data, w_data, b_data,
        output in_addr, w_addr, b_addr, out_valid, out_idx, out_data,
               argmax_idx, argmax_val, busy, done
    );

    modport slave (
        output start, act_mode, in_data, w_data, b_data,
        input  in_addr, w_addr, b_addr, out_valid, out_idx, out_data,
               argmax_idx, argmax_val, busy, done
    );
endinterface

// File: rtl/mlp_layer_engine.sv
// Time-multiplexed fully-connected layer: one MAC walks every neuron, then adds bias,
// applies identity/ReLU, saturates, streams each result and tracks the running argmax.
module mlp_layer_engine #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 64,
    parameter int W      = 16,
    parameter int FRAC_W = 11,
    parameter int BIAS_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mlp_layer_engine_if.master bus
);
    localparam int IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int WA_W   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
    localparam int ACC_W  = 2 * W + $clog2(N_IN) + 1;
    localparam int SUM_W  = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 1;

    localparam logic [IN_AW-1:0]        I_LAST  = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0]       J_LAST  = OUT_AW'(N_OUT - 1);
    localparam logic [WA_W-1:0]         W_STEP  = WA_W'(N_IN);
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]     RES_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]     RES_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_NORM, S_DONE} state_t;

    state_t                  state_q;
    logic                    act_q;
    logic [IN_AW-1:0]        i_q;
    logic [OUT_AW-1:0]       j_q;
    logic [WA_W-1:0]         w_base_q;
    logic [WA_W-1:0]         w_addr_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    out_valid_q;
    logic [OUT_AW-1:0]       out_idx_q;
    logic signed [W-1:0]     out_data_q;
    logic [OUT_AW-1:0]       argmax_idx_q;
    logic signed [W-1:0]     argmax_val_q;
    logic                    busy_q;
    logic                    done_q;

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;
    logic signed [W-1:0]     res;

    always_comb begin
        prod     = (2*W)'(bus.in_data) * (2*W)'(bus.w_data);
        prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
        sum      = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                 + {{(SUM_W-BIAS_W){bus.b_data[BIAS_W-1]}}, bus.b_data};
        // Arithmetic shift floors toward minus infinity, so -1 LSB of bias stays -1.
        shifted  = sum >>> FRAC_W;
        if (act_q && shifted[SUM_W-1]) begin
            res = '0;
        end else if (shifted > SAT_MAX) begin
            res = RES_MAX;
        end else if (shifted < SAT_MIN) begin
            res = RES_MIN;
        end else begin
            res = shifted[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            act_q        <= 1'b0;
            i_q          <= '0;
            j_q          <= '0;
            w_base_q     <= '0;
            w_addr_q     <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_data_q   <= '0;
            argmax_idx_q <= '0;
            argmax_val_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        busy_q       <= 1'b1;
                        act_q        <= bus.act_mode;
                        i_q          <= '0;
                        j_q          <= '0;
                        w_base_q     <= '0;
                        w_addr_q     <= '0;
                        acc_q        <= '0;
                        argmax_idx_q <= '0;
                        argmax_val_q <= '0;
                        state_q      <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Read data lags the address by one cycle, so tap i lands while i+1 is addressed.
                    if (i_q != '0) begin
                        acc_q <= acc_q + prod_ext;
                    end
                    if (i_q == I_LAST) begin
                        state_q <= S_DRAIN;
                    end else begin
                        i_q      <= i_q + IN_AW'(1);
                        w_addr_q <= w_addr_q + WA_W'(1);
                    end
                end
                S_DRAIN: begin
                    acc_q   <= acc_q + prod_ext;
                    state_q <= S_NORM;
                end
                S_NORM: begin
                    out_data_q  <= res;
                    out_idx_q   <= j_q;
                    out_valid_q <= 1'b1;
                    if (j_q == '0 || res > argmax_val_q) begin
                        argmax_idx_q <= j_q;
                        argmax_val_q <= res;
                    end
                    acc_q <= '0;
                    if (j_q == J_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        j_q      <= j_q + OUT_AW'(1);
                        i_q      <= '0;
                        w_base_q <= w_base_q + W_STEP;
                        w_addr_q <= w_base_q + W_STEP;
                        state_q  <= S_MAC;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_addr    = i_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.b_addr     = j_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_data   = out_data_q;
    assign bus.argmax_idx = argmax_idx_q;
    assign bus.argmax_val = argmax_val_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_mlp_layer_engine.sv
// Directed bench for mlp_layer_engine with a 4-input, 3-neuron layer and
// synchronous-read memory models; expected values are hand-computed constants.
module tb_mlp_layer_engine;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 3;
    localparam int W      = 16;
    localparam int FRAC_W = 11;
    localparam int BIAS_W = 32;
    localparam int NCYC   = 26;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic signed [W-1:0]      in_mem [0:3];
    logic signed [W-1:0]      w_mem  [0:15];
    logic signed [BIAS_W-1:0] b_mem  [0:3];

    int   nvalid, ndone, done_cyc, amax_i, amax_v, quiet_cnt;
    int   v_cyc  [0:7];
    int   v_data [0:7];
    int   v_idx  [0:7];
    int   waddr_log [0:NCYC];
    logic busy_log  [0:NCYC];

    mlp_layer_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W), .BIAS_W(BIAS_W)) bus ();

    mlp_layer_engine #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .W     (W),
        .FRAC_W(FRAC_W),
        .BIAS_W(BIAS_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.in_data <= in_mem[bus.in_addr];
        bus.w_data  <= w_mem[bus.w_addr];
        bus.b_data  <= b_mem[bus.b_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input int inv, input int w0, input int w1, input int w2,
                           input int b0, input int b1, input int b2);
        for (int i = 0; i < 4; i++) in_mem[i] = W'(inv);
        for (int k = 0; k < 16; k++) w_mem[k] = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_mem[0*N_IN+i] = W'(w0);
            w_mem[1*N_IN+i] = W'(w1);
            w_mem[2*N_IN+i] = W'(w2);
        end
        b_mem[0] = BIAS_W'(b0);
        b_mem[1] = BIAS_W'(b1);
        b_mem[2] = BIAS_W'(b2);
        b_mem[3] = '0;
    endtask

    // Pulse start, then log every cycle; act_mode is flipped after acceptance to prove latching.
    task automatic run_layer(input logic act, input int extra_start);
        nvalid = 0; ndone = 0; done_cyc = -1; amax_i = -1; amax_v = -1;
        for (int k = 0; k < 8; k++) begin
            v_cyc[k] = 0; v_data[k] = 0; v_idx[k] = 0;
        end
        bus.start    = 1'b1;
        bus.act_mode = act;
        @(negedge clk);
        for (int c = 1; c <= NCYC; c++) begin
            busy_log[c]  = bus.busy;
            waddr_log[c] = int'(bus.w_addr);
            if (bus.out_valid) begin
                if (nvalid < 8) begin
                    v_cyc[nvalid]  = c;
                    v_data[nvalid] = int'(bus.out_data);
                    v_idx[nvalid]  = int'(bus.out_idx);
                end
                nvalid++;
            end
            if (bus.done) begin
                ndone++;
                done_cyc = c;
                amax_i   = int'(bus.argmax_idx);
                amax_v   = int'(bus.argmax_val);
            end
            bus.start    = (c == extra_start);
            bus.act_mode = ~act;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic check_layer(input string tag, input int e0, input int e1, input int e2,
                               input int ai, input int av);
        int e [0:2];
        e[0] = e0; e[1] = e1; e[2] = e2;
        check($sformatf("%s_nvalid", tag), nvalid, 3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_data%0d", tag, k), v_data[k], e[k]);
            check($sformatf("%s_idx%0d", tag, k), v_idx[k], k);
            check($sformatf("%s_cyc%0d", tag, k), v_cyc[k], (k + 1) * (N_IN + 2) + 1);
        end
        check($sformatf("%s_ndone", tag), ndone, 1);
        check($sformatf("%s_donecyc", tag), done_cyc, N_OUT * (N_IN + 2) + 2);
        check($sformatf("%s_amax_idx", tag), amax_i, ai);
        check($sformatf("%s_amax_val", tag), amax_v, av);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_out_valid", tag), bus.out_valid, 0);
        check($sformatf("%s_out_idx", tag), bus.out_idx, 0);
        check($sformatf("%s_out_data", tag), bus.out_data, 0);
        check($sformatf("%s_amax_idx", tag), bus.argmax_idx, 0);
        check($sformatf("%s_amax_val", tag), bus.argmax_val, 0);
        check($sformatf("%s_busy", tag), bus.busy, 0);
        check($sformatf("%s_done", tag), bus.done, 0);
        check($sformatf("%s_in_addr", tag), bus.in_addr, 0);
        check($sformatf("%s_w_addr", tag), bus.w_addr, 0);
        check($sformatf("%s_b_addr", tag), bus.b_addr, 0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.act_mode = 1'b0;
        set_mem(2048, 2048, 1024, -2048, 0, 0, 0);

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // 1: identity, one positive, one half, one negative neuron
        run_layer(1'b0, 0);
        check_layer("s1", 8192, 4096, -8192, 0, 8192);
        check("s1_busy_c1", busy_log[1], 1);
        check("s1_busy_c20", busy_log[20], 1);
        check("s1_busy_c21", busy_log[21], 0);
        check("s1_waddr_c8", waddr_log[8], 5);
        check("s1_hold_data", bus.out_data, -8192);
        check("s1_hold_idx", bus.out_idx, 2);
        check("s1_hold_amax", bus.argmax_val, 8192);

        // 2: ReLU clamps the negative neuron
        run_layer(1'b1, 0);
        check_layer("s2", 8192, 4096, 0, 0, 8192);

        // 3: saturation both ways
        set_mem(32767, 32767, -32768, 0, 0, 0, 0);
        run_layer(1'b0, 0);
        check_layer("s3", 32767, -32768, 0, 0, 32767);

        // 4: bias only, floor rounding
        set_mem(2048, 0, 0, 0, 4194304, -1, 2047);
        run_layer(1'b0, 0);
        check_layer("s4", 2048, -1, 0, 0, 2048);

        // 5: tie keeps lowest index; start while busy ignored
        set_mem(2048, 1024, 0, 1024, 0, 0, 0);
        run_layer(1'b0, 5);
        check_layer("s5", 4096, 0, 4096, 0, 4096);

        // 7: all negative, later neuron wins; first neuron must load
        set_mem(2048, -1024, -2048, -512, 0, 0, 0);
        run_layer(1'b0, 0);
        check_layer("s7", -4096, -8192, -2048, 2, -2048);

        // 8: same with ReLU -> all zero, argmax stays at index 0
        run_layer(1'b1, 0);
        check_layer("s8", 0, 0, 0, 0, 0);

        // 6: reset mid-run, then a clean rerun of scenario 1
        set_mem(2048, 2048, 1024, -2048, 0, 0, 0);
        bus.start    = 1'b1;
        bus.act_mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("s6_amax_live", bus.argmax_val, 8192);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("s6_abort");
        rst = 1'b0;
        quiet_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid || bus.done || bus.busy) quiet_cnt++;
        end
        check("s6_quiet", quiet_cnt, 0);
        run_layer(1'b0, 0);
        check_layer("s6b", 8192, 4096, -8192, 0, 8192);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
